umi_mem_responder: RTL and testbench



---
 rtl/umi_resp_pkg.sv | 15 +
 rtl/umi_mem_responder_ram.sv | 44 ++++
 rtl/umi_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_umi_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/umi_resp_pkg.sv
// Shared UMI responder definitions: opcodes and FSM state encoding.
package umi_resp_pkg;

   localparam logic [4:0] REQ_READ   = 5'h01;
   localparam logic [4:0] REQ_WRITE  = 5'h03;
   localparam logic [4:0] REQ_POSTED = 5'h05;
   localparam logic [4:0] RESP_READ  = 5'h02;
   localparam logic [4:0] RESP_WRITE = 5'h04;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

endpackage

// File: rtl/umi_mem_responder_ram.sv
// Single-port DEPTH x DW synchronous RAM; registered read port returns zero on a write cycle.
module umi_mem_responder_ram #(
   parameter int unsigned DW    = 256,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          we,
   input  logic [IW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem_q[addr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (en) begin
         rdata_d = we ? '0 : mem_q[addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/umi_mem_responder.sv
// UMI memory target endpoint: single outstanding request, responses on a separate UMI port.
// Optional build macro UMI_MEM_RESPONDER_ERRCNT_EN adds a saturating bad-request counter.
module umi_mem_responder
   import umi_resp_pkg::*;
#(
   parameter int unsigned CW    = 32,
   parameter int unsigned AW    = 64,
   parameter int unsigned DW    = 256,
   parameter int unsigned DEPTH = 64,
   parameter logic [15:0] ID    = 16'h0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          umi_in_valid,
   output logic          umi_in_ready,
   input  logic [CW-1:0] umi_in_cmd,
   input  logic [AW-1:0] umi_in_dstaddr,
   input  logic [AW-1:0] umi_in_srcaddr,
   input  logic [DW-1:0] umi_in_data,
   output logic          umi_out_valid,
   input  logic          umi_out_ready,
   output logic [CW-1:0] umi_out_cmd,
   output logic [AW-1:0] umi_out_dstaddr,
   output logic [AW-1:0] umi_out_srcaddr,
   output logic [DW-1:0] umi_out_data,
   output logic          err_sticky
`ifdef UMI_MEM_RESPONDER_ERRCNT_EN
   ,
   output logic [15:0]   err_count
`endif
);

   localparam int unsigned OFF = $clog2(DW / 8);
   localparam int unsigned IW  = $clog2(DEPTH);

   state_e        state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [CW-1:0] out_cmd_q, out_cmd_d;
   logic [AW-1:0] out_dst_q, out_dst_d;
   logic [AW-1:0] out_src_q, out_src_d;
   logic          err_q, err_d;

   logic          fire;
   logic          bad;
   logic [4:0]    op;
   logic [IW-1:0] idx;
   logic          ram_en;
   logic          ram_we;

   assign op   = umi_in_cmd[4:0];
   assign idx  = umi_in_dstaddr[OFF +: IW];
   assign fire = umi_in_valid & in_ready_q;
   assign bad  = fire & ((umi_in_dstaddr[55:40] != ID) ||
                         !((op == REQ_READ) || (op == REQ_WRITE) || (op == REQ_POSTED)));

   always_comb begin
      state_d   = state_q;
      out_cmd_d = out_cmd_q;
      out_dst_d = out_dst_q;
      out_src_d = out_src_q;
      err_d     = err_q;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bad) begin
               err_d = 1'b1;
            end else if (fire) begin
               case (op)
                  REQ_READ: begin
                     ram_en    = 1'b1;
                     out_cmd_d = {umi_in_cmd[CW-1:5], RESP_READ};
                     out_dst_d = umi_in_srcaddr;
                     out_src_d = umi_in_dstaddr;
                     state_d   = ST_RESP;
                  end
                  REQ_WRITE: begin
                     ram_en    = 1'b1;
                     ram_we    = 1'b1;
                     out_cmd_d = {umi_in_cmd[CW-1:5], RESP_WRITE};
                     out_dst_d = umi_in_srcaddr;
                     out_src_d = umi_in_dstaddr;
                     state_d   = ST_RESP;
                  end
                  REQ_POSTED: begin
                     ram_en = 1'b1;
                     ram_we = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_RESP: begin
            if (umi_out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshake flags follow the next state so they stay pure flop outputs.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_cmd_q   <= '0;
         out_dst_q   <= '0;
         out_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_cmd_q   <= out_cmd_d;
         out_dst_q   <= out_dst_d;
         out_src_q   <= out_src_d;
         err_q       <= err_d;
      end
   end

   umi_mem_responder_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (idx),
      .wdata (umi_in_data),
      .rdata (umi_out_data)
   );

`ifdef UMI_MEM_RESPONDER_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bad && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

   assign umi_in_ready    = in_ready_q;
   assign umi_out_valid   = out_valid_q;
   assign umi_out_cmd     = out_cmd_q;
   assign umi_out_dstaddr = out_dst_q;
   assign umi_out_srcaddr = out_src_q;
   assign err_sticky      = err_q;

endmodule

// File: tb/tb_umi_mem_responder.sv
// Directed self-checking bench for umi_mem_responder (default parameters).
module tb_umi_mem_responder;

   localparam int unsigned CW = 32;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 256;

   logic          clk;
   logic          reset;
   logic          umi_in_valid;
   logic          umi_in_ready;
   logic [CW-1:0] umi_in_cmd;
   logic [AW-1:0] umi_in_dstaddr;
   logic [AW-1:0] umi_in_srcaddr;
   logic [DW-1:0] umi_in_data;
   logic          umi_out_valid;
   logic          umi_out_ready;
   logic [CW-1:0] umi_out_cmd;
   logic [AW-1:0] umi_out_dstaddr;
   logic [AW-1:0] umi_out_srcaddr;
   logic [DW-1:0] umi_out_data;
   logic          err_sticky;
`ifdef UMI_MEM_RESPONDER_ERRCNT_EN
   logic [15:0]   err_count;
`endif

   int checks = 0;
   int errors = 0;

   umi_mem_responder dut (
      .clk             (clk),
      .reset           (reset),
      .umi_in_valid    (umi_in_valid),
      .umi_in_ready    (umi_in_ready),
      .umi_in_cmd      (umi_in_cmd),
      .umi_in_dstaddr  (umi_in_dstaddr),
      .umi_in_srcaddr  (umi_in_srcaddr),
      .umi_in_data     (umi_in_data),
      .umi_out_valid   (umi_out_valid),
      .umi_out_ready   (umi_out_ready),
      .umi_out_cmd     (umi_out_cmd),
      .umi_out_dstaddr (umi_out_dstaddr),
      .umi_out_srcaddr (umi_out_srcaddr),
      .umi_out_data    (umi_out_data),
      .err_sticky      (err_sticky)
`ifdef UMI_MEM_RESPONDER_ERRCNT_EN
      ,
      .err_count       (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one request at a negedge; return at the negedge after the accepting edge.
   task automatic send(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                       input logic [AW-1:0] src, input logic [DW-1:0] data);
      umi_in_valid   = 1'b1;
      umi_in_cmd     = cmd;
      umi_in_dstaddr = dst;
      umi_in_srcaddr = src;
      umi_in_data    = data;
      @(posedge clk);
      @(negedge clk);
      umi_in_valid   = 1'b0;
   endtask

   localparam logic [AW-1:0] HOST = 64'h0001_0000_0000_0000;

   logic [DW-1:0] pat_a5;
   logic [CW-1:0] hold_cmd;
   logic [AW-1:0] hold_dst;
   logic [DW-1:0] hold_data;

   initial begin
      pat_a5         = {32{8'hA5}};
      reset          = 1'b1;
      umi_in_valid   = 1'b0;
      umi_in_cmd     = '0;
      umi_in_dstaddr = '0;
      umi_in_srcaddr = '0;
      umi_in_data    = '0;
      umi_out_ready  = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", DW'(umi_in_ready), DW'(1'b0));
      chk("rst_out_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("rst_out_cmd", DW'(umi_out_cmd), '0);
      chk("rst_out_data", umi_out_data, '0);
      chk("rst_err", DW'(err_sticky), DW'(1'b0));
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", DW'(umi_in_ready), DW'(1'b1));

      // Write with upper cmd bits, response swaps addresses and zeroes data
      send(32'hABC0_0003, 64'h40, HOST, pat_a5);
      chk("wr_valid", DW'(umi_out_valid), DW'(1'b1));
      chk("wr_cmd", DW'(umi_out_cmd), DW'(32'hABC0_0004));
      chk("wr_dst", DW'(umi_out_dstaddr), DW'(HOST));
      chk("wr_src", DW'(umi_out_srcaddr), DW'(64'h40));
      chk("wr_data", umi_out_data, '0);
      chk("wr_in_ready", DW'(umi_in_ready), DW'(1'b0));
      @(negedge clk);
      chk("wr_done_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("wr_done_ready", DW'(umi_in_ready), DW'(1'b1));

      // Read back
      send(32'h0000_0001, 64'h40, HOST, '0);
      chk("rd_valid", DW'(umi_out_valid), DW'(1'b1));
      chk("rd_cmd", DW'(umi_out_cmd), DW'(32'h0000_0002));
      chk("rd_dst", DW'(umi_out_dstaddr), DW'(HOST));
      chk("rd_src", DW'(umi_out_srcaddr), DW'(64'h40));
      chk("rd_data", umi_out_data, pat_a5);
      @(negedge clk);

      // Backpressure for 10 cycles
      umi_out_ready = 1'b0;
      send(32'h0000_0001, 64'h40, HOST, '0);
      hold_cmd  = 32'h0000_0002;
      hold_dst  = HOST;
      hold_data = pat_a5;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", DW'(umi_out_valid), DW'(1'b1));
         chk("bp_in_ready", DW'(umi_in_ready), DW'(1'b0));
         chk("bp_cmd", DW'(umi_out_cmd), DW'(hold_cmd));
         chk("bp_dst", DW'(umi_out_dstaddr), DW'(hold_dst));
         chk("bp_data", umi_out_data, hold_data);
         @(negedge clk);
      end
      umi_out_ready = 1'b1;
      chk("bp_last_valid", DW'(umi_out_valid), DW'(1'b1));
      @(negedge clk);
      chk("bp_rel_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("bp_rel_ready", DW'(umi_in_ready), DW'(1'b1));

      // Posted write to index 3, immediately followed by a read of it
      send(32'h0000_0005, 64'h60, HOST, DW'(16'h1234));
      chk("post_no_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("post_ready", DW'(umi_in_ready), DW'(1'b1));
      send(32'h0000_0001, 64'h60, HOST, '0);
      chk("post_rd_valid", DW'(umi_out_valid), DW'(1'b1));
      chk("post_rd_data", umi_out_data, DW'(16'h1234));
      @(negedge clk);

      // Bad opcode and ID mismatch
      send(32'h0000_001F, 64'h60, HOST, DW'(16'hFFFF));
      chk("badop_no_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("badop_err", DW'(err_sticky), DW'(1'b1));
      chk("badop_ready", DW'(umi_in_ready), DW'(1'b1));
      send(32'h0000_0003, 64'h0000_0100_0000_0060, HOST, DW'(16'hDEAD));
      chk("badid_no_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("badid_err", DW'(err_sticky), DW'(1'b1));
`ifdef UMI_MEM_RESPONDER_ERRCNT_EN
      chk("err_count", DW'(err_count), DW'(16'd2));
`endif
      send(32'h0000_0001, 64'h60, HOST, '0);
      chk("bad_mem_kept", umi_out_data, DW'(16'h1234));
      @(negedge clk);

      // Index wrap: DEPTH+5 aliases word 5 (byte addr 0x8A0 vs 0xA0)
      send(32'h0000_0005, 64'hA0, HOST, DW'(8'h55));
      send(32'h0000_0001, 64'h8A0, HOST, '0);
      chk("wrap_valid", DW'(umi_out_valid), DW'(1'b1));
      chk("wrap_data", umi_out_data, DW'(8'h55));
      chk("wrap_src", DW'(umi_out_srcaddr), DW'(64'h8A0));
      @(negedge clk);

      // Reset while a response is pending
      umi_out_ready = 1'b0;
      send(32'h0000_0001, 64'h40, HOST, '0);
      chk("mid_valid", DW'(umi_out_valid), DW'(1'b1));
      #2 reset = 1'b1;
      #1;
      chk("async_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("async_ready", DW'(umi_in_ready), DW'(1'b0));
      chk("async_err", DW'(err_sticky), DW'(1'b0));
      @(negedge clk);
      reset = 1'b0;
      umi_out_ready = 1'b1;
      @(negedge clk);
      chk("rel_ready", DW'(umi_in_ready), DW'(1'b1));
      chk("rel_valid", DW'(umi_out_valid), DW'(1'b0));
      chk("rel_err", DW'(err_sticky), DW'(1'b0));
`ifdef UMI_MEM_RESPONDER_ERRCNT_EN
      chk("rel_err_count", DW'(err_count), '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
